tiny_dnn_seq: RTL and testbench

Loop sequencer for the input/output buffer datapath of the tiny-dnn accelerator. It walks an output-major, input-minor loop nest and drives the input buffer read port (`exec`, `ia`) and the output buffer write/accumulate port (`outr`, `accr`, `oa`). It issues `outr` a fixed MAC latency after the last input of each output, which lines `sum` up with the output buffer write pipeline. It sits between the host/DMA control registers and the `src`/`dst` buffers plus MAC core, and yields the input buffer to DMA writes.

---
 rtl/tiny_dnn_seq.sv | 156 +++++++++++++++
 tb/tb_tiny_dnn_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_dnn_seq.sv
// Loop sequencer for the tiny-dnn input/output buffer datapath: walks outputs (k) over inputs (i),
// drives input-buffer reads and emits output-buffer write strobes LAT cycles after each output's last read.
module tiny_dnn_seq #(
    parameter int LAT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        run_i,
    input  logic [12:0] id_i,
    input  logic [12:0] od_i,
    input  logic [11:0] ib_i,
    input  logic [11:0] istep_i,
    input  logic [11:0] ob_i,
    input  logic        sbank_i,
    input  logic        dbank_i,
    input  logic        acc_i,
    input  logic        src_v_i,
    input  logic        src_a12_i,
    output logic        exec_o,
    output logic [12:0] ia_o,
    output logic        first_o,
    output logic        outr_o,
    output logic        accr_o,
    output logic [12:0] oa_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t      state_q;
    logic [12:0] id_q;
    logic [12:0] od_q;
    logic [11:0] ib_q;
    logic [11:0] istep_q;
    logic [11:0] ob_q;
    logic        sbank_q;
    logic        dbank_q;
    logic        acc_q;
    logic [11:0] i_q;
    logic [11:0] k_q;
    logic [11:0] kstep_q;

    logic [LAT-1:0] dl_v_q;
    logic [11:0]    dl_k_q [LAT];

    logic        pause;
    logic        step;
    logic        last_i;
    logic        last_k;
    logic        pending;
    logic [11:0] addr_lo;

    // DMA writes to the bank being read take priority over the sequencer.
    assign pause   = src_v_i & (src_a12_i == sbank_q);
    assign step    = (state_q == RUN) & ~pause;
    assign last_i  = ({1'b0, i_q} == (id_q - 13'd1));
    assign last_k  = ({1'b0, k_q} == (od_q - 13'd1));
    assign addr_lo = ib_q + kstep_q + i_q;

    // Entries that will still be in the line after the next shift.
    always_comb begin
        pending = 1'b0;
        for (int j = 0; j < LAT - 1; j++) begin
            pending = pending | dl_v_q[j];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            od_q    <= '0;
            ib_q    <= '0;
            istep_q <= '0;
            ob_q    <= '0;
            sbank_q <= 1'b0;
            dbank_q <= 1'b0;
            acc_q   <= 1'b0;
            i_q     <= '0;
            k_q     <= '0;
            kstep_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run_i) begin
                        id_q    <= id_i;
                        od_q    <= od_i;
                        ib_q    <= ib_i;
                        istep_q <= istep_i;
                        ob_q    <= ob_i;
                        sbank_q <= sbank_i;
                        dbank_q <= dbank_i;
                        acc_q   <= acc_i;
                        i_q     <= '0;
                        k_q     <= '0;
                        kstep_q <= '0;
                        state_q <= ((id_i == 13'd0) || (od_i == 13'd0)) ? FIN : RUN;
                    end
                end
                RUN: begin
                    if (step) begin
                        if (last_i) begin
                            i_q     <= '0;
                            k_q     <= k_q + 12'd1;
                            kstep_q <= kstep_q + istep_q;
                            if (last_k) begin
                                state_q <= DRAIN;
                            end
                        end else begin
                            i_q <= i_q + 12'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // MAC latency line: carries the output index of each completed output.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int j = 0; j < LAT; j++) begin
                dl_v_q[j] <= 1'b0;
                dl_k_q[j] <= '0;
            end
        end else begin
            dl_v_q[0] <= step & last_i;
            dl_k_q[0] <= k_q;
            for (int j = 1; j < LAT; j++) begin
                dl_v_q[j] <= dl_v_q[j-1];
                dl_k_q[j] <= dl_k_q[j-1];
            end
        end
    end

    assign exec_o  = step;
    assign ia_o    = step ? {sbank_q, addr_lo} : 13'd0;
    assign first_o = step & (i_q == 12'd0);
    assign outr_o  = dl_v_q[LAT-1];
    assign accr_o  = dl_v_q[LAT-1] & acc_q;
    assign oa_o    = dl_v_q[LAT-1] ? {dbank_q, ob_q + dl_k_q[LAT-1]} : 13'd0;
    assign busy_o  = (state_q == RUN) || (state_q == DRAIN);
    assign done_o  = (state_q == FIN);

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Scoreboard bench for tiny_dnn_seq: directed runs push expected events, a negedge monitor pops and compares.
module tb_tiny_dnn_seq;

    localparam int LAT = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        run_i;
    logic [12:0] id_i;
    logic [12:0] od_i;
    logic [11:0] ib_i;
    logic [11:0] istep_i;
    logic [11:0] ob_i;
    logic        sbank_i;
    logic        dbank_i;
    logic        acc_i;
    logic        src_v_i;
    logic        src_a12_i;
    logic        exec_o;
    logic [12:0] ia_o;
    logic        first_o;
    logic        outr_o;
    logic        accr_o;
    logic [12:0] oa_o;
    logic        busy_o;
    logic        done_o;

    tiny_dnn_seq #(.LAT(LAT)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .run_i(run_i),
        .id_i(id_i), .od_i(od_i), .ib_i(ib_i), .istep_i(istep_i), .ob_i(ob_i),
        .sbank_i(sbank_i), .dbank_i(dbank_i), .acc_i(acc_i),
        .src_v_i(src_v_i), .src_a12_i(src_a12_i),
        .exec_o(exec_o), .ia_o(ia_o), .first_o(first_o),
        .outr_o(outr_o), .accr_o(accr_o), .oa_o(oa_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        logic [12:0] a;
        logic        f;
    } ev_t;

    ev_t exec_q[$];
    ev_t outr_q[$];
    ev_t done_q[$];

    int cyc      = 0;
    int base     = 0;
    int checks   = 0;
    int errors   = 0;
    int busy_lo  = 0;
    int busy_hi  = -1;
    bit busy_chk = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at rel cycle %0d: got %0h expected %0h", name, cyc - base, act, exp);
        end
    endfunction

    task automatic px(int c, int a, bit f);
        ev_t e;
        e.cyc = base + c; e.a = 13'(a); e.f = f;
        exec_q.push_back(e);
    endtask

    task automatic po(int c, int a, bit accr);
        ev_t e;
        e.cyc = base + c; e.a = 13'(a); e.f = accr;
        outr_q.push_back(e);
    endtask

    task automatic pd(int c);
        ev_t e;
        e.cyc = base + c; e.a = 13'd0; e.f = 1'b1;
        done_q.push_back(e);
    endtask

    task automatic busy_win(int lo, int hi);
        busy_lo  = base + lo;
        busy_hi  = base + hi;
        busy_chk = 1'b1;
    endtask

    // Monitor: one line per observed transaction, compared against the scoreboard head.
    always @(negedge clk_i) begin
        ev_t e;
        if (exec_o) begin
            $display("exec  rel=%0d ia=%h first=%b", cyc - base, ia_o, first_o);
            if (exec_q.size() == 0) check("exec_unexpected", 1, 0);
            else begin
                e = exec_q.pop_front();
                check("exec_cycle", cyc - base, e.cyc - base);
                check("ia", int'(ia_o), int'(e.a));
                check("first", int'(first_o), int'(e.f));
            end
        end else if (first_o) begin
            check("first_without_exec", 1, 0);
        end
        if (outr_o) begin
            $display("outr  rel=%0d oa=%h accr=%b", cyc - base, oa_o, accr_o);
            if (outr_q.size() == 0) check("outr_unexpected", 1, 0);
            else begin
                e = outr_q.pop_front();
                check("outr_cycle", cyc - base, e.cyc - base);
                check("oa", int'(oa_o), int'(e.a));
                check("accr", int'(accr_o), int'(e.f));
            end
        end else if (accr_o) begin
            check("accr_without_outr", 1, 0);
        end
        if (done_o) begin
            $display("done  rel=%0d", cyc - base);
            if (done_q.size() == 0) check("done_unexpected", 1, 0);
            else begin
                e = done_q.pop_front();
                check("done_cycle", cyc - base, e.cyc - base);
            end
        end
        if (busy_chk) check("busy", int'(busy_o), int'(cyc >= busy_lo && cyc <= busy_hi));
    end

    task automatic cfg(int nid, int nod, int nib, int nist, int nob, bit sb, bit db, bit ac);
        id_i = 13'(nid); od_i = 13'(nod); ib_i = 12'(nib); istep_i = 12'(nist);
        ob_i = 12'(nob); sbank_i = sb; dbank_i = db; acc_i = ac;
    endtask

    task automatic launch();
        @(posedge clk_i); #1;
        base = cyc;
    endtask

    task automatic pulse();
        run_i = 1'b1;
        @(posedge clk_i); #1;
        run_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60 && (exec_q.size() + outr_q.size() + done_q.size()) > 0; n++)
            @(posedge clk_i);
        repeat (2) @(posedge clk_i);
        #1;
        check("pending_events", exec_q.size() + outr_q.size() + done_q.size(), 0);
        exec_q.delete(); outr_q.delete(); done_q.delete();
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_exec"}, int'(exec_o), 0);
        check({tag, "_ia"}, int'(ia_o), 0);
        check({tag, "_first"}, int'(first_o), 0);
        check({tag, "_outr"}, int'(outr_o), 0);
        check({tag, "_accr"}, int'(accr_o), 0);
        check({tag, "_oa"}, int'(oa_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_done"}, int'(done_o), 0);
    endtask

    task automatic fc_expect();
        px(1, 0, 1); px(2, 1, 0); px(3, 2, 0); px(4, 0, 1); px(5, 1, 0); px(6, 2, 0);
        po(7, 'h1005, 0); po(10, 'h1006, 0);
        pd(11);
        busy_win(1, 10);
    endtask

    task automatic test_fc();
        cfg(3, 2, 0, 0, 5, 0, 1, 0);
        launch(); fc_expect(); pulse();
        wait_idle();
    endtask

    task automatic test_pause(bit a12);
        cfg(3, 2, 0, 0, 5, 0, 1, 0);
        launch();
        if (a12) fc_expect();
        else begin
            px(1, 0, 1); px(4, 1, 0); px(5, 2, 0); px(6, 0, 1); px(7, 1, 0); px(8, 2, 0);
            po(9, 'h1005, 0); po(12, 'h1006, 0);
            pd(13);
            busy_win(1, 12);
        end
        pulse();
        @(posedge clk_i); #1; src_v_i = 1'b1; src_a12_i = a12;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1; src_v_i = 1'b0; src_a12_i = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; run_i = 1'b0; src_v_i = 1'b0; src_a12_i = 1'b0;
        cfg(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        reset_i = 1'b0;

        test_fc();

        // Conv stride with address wrap on bank 1.
        cfg(2, 3, 'hFFE, 1, 0, 1, 0, 0);
        launch();
        px(1, 'h1FFE, 1); px(2, 'h1FFF, 0); px(3, 'h1FFF, 1);
        px(4, 'h1000, 0); px(5, 'h1000, 1); px(6, 'h1001, 0);
        po(6, 'h000, 0); po(8, 'h001, 0); po(10, 'h002, 0);
        pd(11); busy_win(1, 10);
        pulse();
        wait_idle();

        test_pause(1'b0);
        test_pause(1'b1);

        // Accumulate with id==1: back-to-back strobes.
        cfg(1, 4, 'h100, 2, 'h010, 0, 0, 1);
        launch();
        px(1, 'h100, 1); px(2, 'h102, 1); px(3, 'h104, 1); px(4, 'h106, 1);
        po(5, 'h010, 1); po(6, 'h011, 1); po(7, 'h012, 1); po(8, 'h013, 1);
        pd(9); busy_win(1, 8);
        pulse();
        wait_idle();

        // Degenerate runs.
        cfg(3, 0, 0, 0, 5, 0, 1, 0);
        launch(); pd(1); busy_win(1, 0); pulse();
        wait_idle();
        cfg(0, 2, 0, 0, 5, 0, 1, 0);
        launch(); pd(1); busy_win(1, 0); pulse();
        wait_idle();

        // run re-pulsed while busy with altered configuration.
        cfg(3, 2, 0, 0, 5, 0, 1, 0);
        launch(); fc_expect(); pulse();
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        run_i = 1'b1; id_i = 13'd7; ib_i = 12'h123; acc_i = 1'b1;
        @(posedge clk_i); #1;
        run_i = 1'b0;
        wait_idle();

        // Reset mid-run: only the first two reads may appear.
        cfg(3, 2, 0, 0, 5, 0, 1, 0);
        launch();
        px(1, 0, 1); px(2, 1, 0);
        busy_chk = 1'b0;
        pulse();
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        check("midreset_leftover", exec_q.size() + outr_q.size() + done_q.size(), 0);
        exec_q.delete(); outr_q.delete(); done_q.delete();

        test_fc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
